// File: rtl/pwm_demod_pkg.sv
// pwm_demod_pkg: shared types and constants for the PWM demodulator.
//   state_e        : tracking state (HUNT before the first rising edge, LOCK after)
//   DEFAULT_PERIOD : default PWM frame length in clocks
//   calc_sw()      : sample width able to hold 0..PERIOD inclusive
package pwm_demod_pkg;

    localparam int DEFAULT_PERIOD = 256;

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_e;

    function automatic int calc_sw(input int period);
        return $clog2(period) + 1;
    endfunction

endpackage

// File: rtl/pwm_demod_if.sv
// pwm_demod_if: decoded-sample output bundle of the PWM demodulator.
//   sample_o       : last decoded sample (SW bits)
//   sample_valid_o : one-cycle strobe when sample_o updates
//   locked_o       : high while a frame is being tracked
//   resync_o       : one-cycle pulse when an out-of-phase rise forces a re-align
//   state_o        : tracking state, for debug and checkers
// Handshake: sample_valid_o is a pure strobe with no ready/back-pressure; the
// consumer must take sample_o in the cycle sample_valid_o is high, after which
// sample_o holds until the next strobe.
// Modports: master drives the bundle (demodulator), slave observes it.
interface pwm_demod_if #(
    parameter int SW = 9
);
    import pwm_demod_pkg::*;

    logic [SW-1:0] sample_o;
    logic          sample_valid_o;
    logic          locked_o;
    logic          resync_o;
    state_e        state_o;

    modport master (
        output sample_o,
        output sample_valid_o,
        output locked_o,
        output resync_o,
        output state_o
    );

    modport slave (
        input sample_o,
        input sample_valid_o,
        input locked_o,
        input resync_o,
        input state_o
    );

endinterface

// File: rtl/pwm_sync.sv
// pwm_sync: 2-FF synchronizer for a single asynchronous input.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears both stages
//   d_i   : asynchronous input
//   q_o   : synchronized output, 2 cycles after d_i is sampled
module pwm_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pwm_demod.sv
// pwm_demod: recovers sample values from a left-aligned PWM stream by counting
// high cycles in each PERIOD-clock frame; one sample per frame with a strobe.
//   clk     : single clock, rising edge
//   rst_n   : asynchronous active-low reset
//   pwm_i   : PWM stream, asynchronous to clk
//   demod_o : pwm_demod_if.master (sample_o, sample_valid_o, locked_o,
//             resync_o, state_o)
// Parameters: PERIOD (frame length, >= 4), SW (sample width, holds 0..PERIOD).
// Build option: define PWM_DEMOD_AVG_EN to output the rounded average of the
// current and previous raw sample instead of the raw count.
module pwm_demod
    import pwm_demod_pkg::*;
#(
    parameter int PERIOD = DEFAULT_PERIOD,
    parameter int SW     = calc_sw(PERIOD)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pwm_i,
    pwm_demod_if.master demod_o
);

    localparam int CW = $clog2(PERIOD);

    logic          s;
    logic          s_d_q;
    logic          rise;
    logic          frame_end;
    logic [SW-1:0] raw;

    state_e        state_q, state_d;
    logic [CW-1:0] frame_cnt_q, frame_cnt_d;
    logic [SW-1:0] hi_cnt_q, hi_cnt_d;
    logic [SW-1:0] sample_q, sample_d;
    logic          valid_q, valid_d;
    logic          resync_q, resync_d;

    pwm_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (pwm_i),
        .q_o   (s)
    );

    assign rise      = s & ~s_d_q;
    assign frame_end = (frame_cnt_q == CW'(PERIOD - 1));
    // The final cycle of the frame is still counted into the captured sample.
    assign raw       = hi_cnt_q + SW'(s);

`ifdef PWM_DEMOD_AVG_EN
    logic [SW-1:0] prev_q, prev_d;
    logic          first_q, first_d;
    logic [SW:0]   avg_sum;

    // One extra bit so PERIOD + PERIOD + 1 cannot wrap before the halving.
    assign avg_sum = {1'b0, raw} + {1'b0, prev_q} + (SW + 1)'(1);
`endif

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        hi_cnt_d    = hi_cnt_q;
        sample_d    = sample_q;
        valid_d     = 1'b0;
        resync_d    = 1'b0;
`ifdef PWM_DEMOD_AVG_EN
        prev_d      = prev_q;
        first_d     = first_q;
`endif
        case (state_q)
            HUNT: begin
                frame_cnt_d = '0;
                hi_cnt_d    = '0;
                if (rise) begin
                    // The rise cycle is index 0 and is itself a high cycle.
                    state_d     = LOCK;
                    frame_cnt_d = CW'(1);
                    hi_cnt_d    = SW'(1);
`ifdef PWM_DEMOD_AVG_EN
                    first_d     = 1'b1;
`endif
                end
            end
            LOCK: begin
                // An out-of-phase rise beats a frame end in the same cycle.
                if (rise && (frame_cnt_q != '0)) begin
                    frame_cnt_d = CW'(1);
                    hi_cnt_d    = SW'(1);
                    resync_d    = 1'b1;
                end else if (frame_end) begin
                    frame_cnt_d = '0;
                    hi_cnt_d    = '0;
                    valid_d     = 1'b1;
`ifdef PWM_DEMOD_AVG_EN
                    prev_d      = raw;
                    first_d     = 1'b0;
                    sample_d    = first_q ? raw : SW'(avg_sum >> 1);
`else
                    sample_d    = raw;
`endif
                end else begin
                    frame_cnt_d = frame_cnt_q + CW'(1);
                    hi_cnt_d    = raw;
                end
            end
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_d_q       <= 1'b0;
            state_q     <= HUNT;
            frame_cnt_q <= '0;
            hi_cnt_q    <= '0;
            sample_q    <= '0;
            valid_q     <= 1'b0;
            resync_q    <= 1'b0;
        end else begin
            s_d_q       <= s;
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            hi_cnt_q    <= hi_cnt_d;
            sample_q    <= sample_d;
            valid_q     <= valid_d;
            resync_q    <= resync_d;
        end
    end

`ifdef PWM_DEMOD_AVG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q  <= '0;
            first_q <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            first_q <= first_d;
        end
    end
`endif

    assign demod_o.sample_o       = sample_q;
    assign demod_o.sample_valid_o = valid_q;
    assign demod_o.locked_o       = (state_q == LOCK);
    assign demod_o.resync_o       = resync_q;
    assign demod_o.state_o        = state_q;

endmodule

// File: tb/tb_pwm_demod.sv
// tb_pwm_demod: scoreboard bench for pwm_demod. Each phase builds a PWM
// waveform (one bit per clock), a reference model derives the expected
// samples/resyncs with their arrival ticks from frame arithmetic on that
// waveform, and a negedge monitor pops and compares as the DUT presents them.
// Define PWM_DEMOD_AVG_EN for both bench and RTL to check the averaging build.
module tb_pwm_demod;
    import pwm_demod_pkg::*;

    localparam int P  = 256;
    localparam int SW = calc_sw(P);
    // Wave index i is driven at tick T0+i; its effect is visible at T0+i+3.
    localparam int LAT = 3;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic pwm_i = 1'b0;

    always #5 clk = ~clk;

    int tick = 0;
    always @(posedge clk) tick <= tick + 1;

    pwm_demod_if #(.SW(SW)) dm ();

    pwm_demod #(.PERIOD(P), .SW(SW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .pwm_i   (pwm_i),
        .demod_o (dm)
    );

    // ---------------- scoreboard state ----------------
    int            n_tests = 0;
    int            n_fail  = 0;
    logic [SW-1:0] exp_q[$];
    int            exp_t_q[$];
    int            res_q[$];
    int            lock_tick = -1;
    logic [SW-1:0] last_sample = '0;
    bit            wave_q[$];
    logic [SW-1:0] mon_v;
    int            mon_t;

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (tick %0d)", name, act, req, tick);
        end
    endtask

    // ---------------- reference model ----------------
    // A frame is anchored at the first rise (or at any rise that is not a
    // whole number of frames after the anchor). Each complete PERIOD window
    // from the anchor yields a sample equal to its count of high cycles.
    task automatic build_expect(input int t0);
        int anchor = -1;
        bit prevw  = 1'b0;
        int raw;
        int out;
`ifdef PWM_DEMOD_AVG_EN
        bit first    = 1'b1;
        int prev_raw = 0;
`endif
        for (int i = 0; i < wave_q.size(); i++) begin
            bit r;
            r = wave_q[i] && !prevw;
            if (anchor < 0) begin
                if (r) begin
                    anchor    = i;
                    lock_tick = t0 + i + LAT;
                end
            end else if (r && (((i - anchor) % P) != 0)) begin
                res_q.push_back(t0 + i + LAT);
                anchor = i;
            end else if (((i - anchor) % P) == P - 1) begin
                raw = 0;
                for (int j = i - P + 1; j <= i; j++) raw += int'(wave_q[j]);
`ifdef PWM_DEMOD_AVG_EN
                out      = first ? raw : (raw + prev_raw + 1) >> 1;
                first    = 1'b0;
                prev_raw = raw;
`else
                out = raw;
`endif
                exp_q.push_back(SW'(out));
                exp_t_q.push_back(t0 + i + LAT);
            end
            prevw = wave_q[i];
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic push_lvl(input bit v, input int n);
        repeat (n) wave_q.push_back(v);
    endtask

    task automatic push_frame(input int d, input int len);
        push_lvl(1'b1, d);
        push_lvl(1'b0, len - d);
    endtask

    task automatic run_wave(input bit drain);
        int t0;
        @(negedge clk);
        t0 = tick;
        build_expect(t0);
        for (int i = 0; i < wave_q.size(); i++) begin
            if (i > 0) @(negedge clk);
            pwm_i = wave_q[i];
        end
        if (drain) repeat (LAT) @(negedge clk);
        #2;
    endtask

    task automatic check_zero_outputs();
        check("rst_sample_o", int'(dm.sample_o), 0);
        check("rst_sample_valid_o", int'(dm.sample_valid_o), 0);
        check("rst_locked_o", int'(dm.locked_o), 0);
        check("rst_resync_o", int'(dm.resync_o), 0);
    endtask

    // Called mid-cycle: reset must clear the outputs without waiting for clk.
    task automatic apply_reset();
        check("pending_strobes", exp_q.size(), 0);
        check("pending_resyncs", res_q.size(), 0);
        rst_n       = 1'b0;
        lock_tick   = -1;
        last_sample = '0;
        pwm_i       = 1'b0;
        #1;
        check_zero_outputs();
        exp_q.delete();
        exp_t_q.delete();
        res_q.delete();
        wave_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            check("locked_o", int'(dm.locked_o),
                  (lock_tick >= 0 && tick >= lock_tick) ? 1 : 0);
            if (dm.sample_valid_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", 1, 0);
                end else begin
                    mon_v = exp_q.pop_front();
                    mon_t = exp_t_q.pop_front();
                    check("sample_value", int'(dm.sample_o), int'(mon_v));
                    check("strobe_tick", tick, mon_t);
                    last_sample = mon_v;
                end
            end else begin
                check("sample_hold", int'(dm.sample_o), int'(last_sample));
            end
            if (dm.resync_o === 1'b1) begin
                if (res_q.size() == 0) check("unexpected_resync", 1, 0);
                else check("resync_tick", tick, res_q.pop_front());
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion (tick %0d)", tick);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        #1;
        check_zero_outputs();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Steady duty 64 for four frames.
        push_lvl(1'b0, 10);
        repeat (4) push_frame(64, P);
        run_wave(1'b1);
        apply_reset();

        // Lock at duty 100, then two frames low and two frames high.
        push_lvl(1'b0, 7);
        push_frame(100, P);
        push_lvl(1'b0, 2 * P);
        push_lvl(1'b1, 2 * P);
        run_wave(1'b1);
        apply_reset();

        // Rise 37 cycles early, then a rise landing on the last frame index.
        push_lvl(1'b0, 3);
        repeat (2) push_frame(128, P);
        push_frame(128, P - 37);
        repeat (2) push_frame(128, P);
        push_frame(128, P - 1);
        push_frame(128, P);
        run_wave(1'b1);
        apply_reset();

        // Reset at index 150 of the second duty-32 frame.
        push_lvl(1'b0, 5);
        push_frame(32, P);
        push_frame(32, 150);
        run_wave(1'b0);
        apply_reset();

        // Recovery after reset: first sample one frame after the first rise.
        push_lvl(1'b0, 20);
        repeat (3) push_frame(32, P);
        run_wave(1'b1);
        apply_reset();

        // Sample sequence exercising the averaging rounding and full scale.
        push_lvl(1'b0, 4);
        push_frame(64, P);
        push_frame(66, P);
        push_frame(65, P);
        push_frame(0, P);
        push_frame(P, P);
        run_wave(1'b1);
        apply_reset();

        // Random duties with occasional misaligned frame lengths.
        push_lvl(1'b0, $urandom_range(1, 40));
        repeat (12) begin
            int len;
            len = ($urandom_range(0, 3) == 0) ? $urandom_range(4, 300) : P;
            push_frame($urandom_range(0, len), len);
        end
        run_wave(1'b1);
        apply_reset();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_demod.md
# pwm_demod

Recovers audio sample values from a left-aligned PWM stream, as produced by the synth's PWM output stage. Counts the high cycles in each fixed-length PWM frame and emits one sample per frame with a valid strobe. It is the receive end of the synth's PWM link. It is used for loopback self-check on the board (synth `pwm_out` into `pwm_i`) and as a decode/scoreboard element in the synth test environment.

## Interface
- `PERIOD`, 256: PWM frame length in clocks, ≥4. Must equal the transmitter's frame length.
- `SW`, `$clog2(PERIOD)+1`: sample width. It must hold values 0..PERIOD inclusive.
- `clk` in 1: single clock. All logic runs on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `pwm_i` in 1: PWM stream, asynchronous to `clk`. It is synchronized internally.
- `sample_o` out SW: last decoded sample. Resets to 0.
- `sample_valid_o` out 1: one-cycle strobe when `sample_o` updates. Resets to 0.
- `locked_o` out 1: high while a frame is being tracked. Resets to 0.
- `resync_o` out 1: one-cycle pulse when an out-of-phase rising edge forces a re-align. Resets to 0.

## Operation
- **Synchronization:** `pwm_i` passes through a 2-FF synchronizer to give `s`. `s_d` is `s` delayed by one cycle. The rise signal `rise = s & ~s_d`.
- **Counters:**
  - `frame_cnt` counts 0..PERIOD-1. Index 0 is the frame's rising-edge cycle.
  - `hi_cnt` is SW bits wide and counts the cycles in which `s`=1 within the frame.
- **State HUNT (reset state):**
  - Counters are held at 0.
  - On `rise`: go to LOCK, set `frame_cnt`<=1 and `hi_cnt`<=1.
- **State LOCK:**
  - `locked_o`=1.
  - Each cycle: `frame_cnt`++ and `hi_cnt` += `s`.
- **End of frame** (`frame_cnt`==PERIOD-1):
  - Capture `hi_cnt + s` into the sample path.
  - Set `frame_cnt`<=0 and `hi_cnt`<=0.
  - Assert `sample_valid_o` on the next cycle, together with the new `sample_o`.
- **Rise at index 0:** expected. No action beyond normal counting.
- **Rise at index ≠0:**
  - Discard the partial frame; no sample is emitted.
  - Set `frame_cnt`<=1 and `hi_cnt`<=1.
  - Pulse `resync_o` on the next cycle.
  - Remain in LOCK.
- **No rise for a whole frame:** legal.
  - Duty 0 (stream held low) yields sample 0.
  - Duty PERIOD (stream held high) yields sample PERIOD.
  - LOCK is never left except by reset.
- **Arithmetic:** `hi_cnt` is unsigned and cannot exceed PERIOD, so it never overflows SW bits.
- **Simultaneous events:** a rise at index PERIOD-1 counts as out-of-phase. Resync wins and the ending frame emits no sample.

## Timing
- `pwm_i` to `s`: 2 cycles.
- `sample_valid_o` is high exactly 1 cycle. It occurs PERIOD cycles after the frame's index-0 cycle, i.e. one cycle after index PERIOD-1.
- In steady lock, consecutive `sample_valid_o` pulses are exactly PERIOD cycles apart.
- `sample_o` holds its value between strobes.
- `locked_o` rises the cycle after the first detected rise.
- **Reset mid-operation:** all outputs and state return to reset values immediately (asynchronously). This includes clearing the synchronizer. The block re-enters HUNT, and the first sample appears one full frame after the next rise.

## Configuration
- `PWM_DEMOD_AVG_EN` defined: `sample_o` = (current + previous + 1) >> 1, computed in SW+1 bits and truncated to SW bits.
  - The previous-sample register is reset to 0.
  - The first sample after lock (from HUNT) is output unaveraged and loads the previous-sample register.
  - A resync does not clear the previous-sample register.
  - Latency is unchanged, with no extra cycle.
- Undefined: `sample_o` = raw count, and no previous-sample register is built.

## Structure
- `pwm_demod_pkg`:
  - state enum (`HUNT`, `LOCK`)
  - default `PERIOD`
  - a function computing SW from PERIOD
- Sub-module `pwm_sync`: a 2-FF synchronizer with async active-low reset, shared with other async inputs in the synth design.

## Test plan
- Lock, then 4 frames at duty 64 with PERIOD=256 → `sample_o`=64 on each strobe, strobes 256 cycles apart, `resync_o` never pulses.
- Lock at duty 100, then hold `pwm_i` low for 2 frames → samples 0, 0. Then hold high for 2 frames → samples 256, 256. `locked_o` stays 1 throughout.
- Steady duty 128, then shift the next rising edge 37 cycles early → `resync_o` pulses once, the partial frame gives no strobe, and the next strobe is 128, 256 cycles after the shifted rise.
- Assert `rst_n` low at index 150 of a frame → all outputs 0 immediately. After release plus duty 32 frames → first strobe 32, exactly one frame after the first post-reset rise.
- With `PWM_DEMOD_AVG_EN`, duty sequence 64, 66, 65 → outputs 64, 65, 66 (rounded: (66+64+1)>>1=65, (65+66+1)>>1=66).
- With `PWM_DEMOD_AVG_EN`, duty sequence 0, 256 → outputs 0, 128, with no width overflow.
